// File: rtl/xadc_drp_responder.sv
// rtl/xadc_drp_responder.sv - XADC-compatible DRP responder with periodic temperature conversion
module xadc_drp_responder #(
    parameter int CONV_CYCLES = 100,
    parameter int RD_LATENCY  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  daddr_in,
    input  logic        den_in,
    input  logic        dwe_in,
    input  logic [15:0] di_in,
    output logic [15:0] do_out,
    output logic        drdy_out,
    output logic        eoc_out,
    input  logic [11:0] sample_in,
    output logic        err_out
);

    localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
    localparam logic [LW-1:0] LAT_LOAD  = LW'(RD_LATENCY - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [CW-1:0] conv_cnt_q, conv_cnt_d;
    logic          eoc_q, eoc_d;
    logic [15:0]   temp_q, temp_d;
    logic [15:0]   max_q, max_d;
    logic [15:0]   min_q, min_d;
    logic [15:0]   cfg0_q, cfg0_d;
    logic [15:0]   cfg1_q, cfg1_d;
    logic [15:0]   cfg2_q, cfg2_d;
    logic [0:0]    state_q, state_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [6:0]    addr_q, addr_d;
    logic          we_q, we_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   do_q, do_d;
    logic          drdy_q, drdy_d;
    logic          err_q, err_d;

    logic          conv_done;
    logic [15:0]   new_sample;
    logic [15:0]   rd_data;

    assign conv_done  = (conv_cnt_q == CONV_LAST);
    assign new_sample = {sample_in, 4'h0};

    // Read mux uses the registered (pre-update) values, so a read completing on
    // a conversion edge returns the old sample.
    always_comb begin
        rd_data = 16'h0000;
        case (addr_q)
            7'h00:   rd_data = temp_q;
            7'h20:   rd_data = max_q;
            7'h24:   rd_data = min_q;
            7'h40:   rd_data = cfg0_q;
            7'h41:   rd_data = cfg1_q;
            7'h42:   rd_data = cfg2_q;
            default: rd_data = 16'h0000;
        endcase
    end

    always_comb begin
        conv_cnt_d = conv_done ? '0 : conv_cnt_q + 1'b1;
        eoc_d      = conv_done;
        temp_d     = temp_q;
        max_d      = max_q;
        min_d      = min_q;
        cfg0_d     = cfg0_q;
        cfg1_d     = cfg1_q;
        cfg2_d     = cfg2_q;
        state_d    = state_q;
        lat_d      = lat_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        do_d       = do_q;
        drdy_d     = 1'b0;
        err_d      = err_q;

        if (conv_done) begin
            temp_d = new_sample;
            if (new_sample > max_q) max_d = new_sample;
            if (new_sample < min_q) min_d = new_sample;
        end

        case (state_q)
            S_IDLE: begin
                if (den_in) begin
                    addr_d  = daddr_in;
                    we_d    = dwe_in;
                    wdata_d = di_in;
                    lat_d   = LAT_LOAD;
                    state_d = S_WAIT;
                end
            end
            default: begin
                if (den_in) err_d = 1'b1;
                if (lat_q == '0) begin
                    drdy_d  = 1'b1;
                    state_d = S_IDLE;
                    if (we_q) begin
                        do_d = 16'h0000;
                        case (addr_q)
                            7'h40:   cfg0_d = wdata_q;
                            7'h41:   cfg1_d = wdata_q;
                            7'h42:   cfg2_d = wdata_q;
                            default: ;
                        endcase
                    end else begin
                        do_d = rd_data;
                    end
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_cnt_q <= '0;
            eoc_q      <= 1'b0;
            temp_q     <= 16'h0000;
            max_q      <= 16'h0000;
            min_q      <= 16'hFFFF;
            cfg0_q     <= 16'h0000;
            cfg1_q     <= 16'h0000;
            cfg2_q     <= 16'h0000;
            state_q    <= S_IDLE;
            lat_q      <= '0;
            addr_q     <= 7'h00;
            we_q       <= 1'b0;
            wdata_q    <= 16'h0000;
            do_q       <= 16'h0000;
            drdy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            conv_cnt_q <= conv_cnt_d;
            eoc_q      <= eoc_d;
            temp_q     <= temp_d;
            max_q      <= max_d;
            min_q      <= min_d;
            cfg0_q     <= cfg0_d;
            cfg1_q     <= cfg1_d;
            cfg2_q     <= cfg2_d;
            state_q    <= state_d;
            lat_q      <= lat_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            do_q       <= do_d;
            drdy_q     <= drdy_d;
            err_q      <= err_d;
        end
    end

    assign do_out   = do_q;
    assign drdy_out = drdy_q;
    assign eoc_out  = eoc_q;
    assign err_out  = err_q;

endmodule

// File: tb/tb_xadc_drp_responder.sv
// tb/tb_xadc_drp_responder.sv - directed self-checking bench for xadc_drp_responder
module tb_xadc_drp_responder;

    localparam int CC = 100;
    localparam int RL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  daddr = 7'h00;
    logic        den = 1'b0;
    logic        dwe = 1'b0;
    logic [15:0] di = 16'h0000;
    logic [15:0] do_w;
    logic        drdy_w;
    logic        eoc_w;
    logic [11:0] sample = 12'h9C4;
    logic        err_w;

    int checks = 0;
    int errors = 0;
    int edges  = 0;
    int e_seen;
    int drdy_hits;

    xadc_drp_responder #(.CONV_CYCLES(CC), .RD_LATENCY(RL)) dut (
        .clk(clk), .rst(rst), .daddr_in(daddr), .den_in(den), .dwe_in(dwe),
        .di_in(di), .do_out(do_w), .drdy_out(drdy_w), .eoc_out(eoc_w),
        .sample_in(sample), .err_out(err_w)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        edges = 0;
    endtask

    // Issue one DRP transaction; den sampled at edge n, completion at n+RL
    task automatic txn(input logic [6:0] a, input logic we, input logic [15:0] d,
                       input logic [15:0] exp, input string tag);
        daddr = a; dwe = we; di = d; den = 1'b1;
        step();
        den = 1'b0; dwe = 1'b0;
        for (int i = 1; i < RL; i++) step();
        chk({tag, "_early_drdy"}, {31'd0, drdy_w}, 32'd0);
        step();
        chk({tag, "_drdy"}, {31'd0, drdy_w}, 32'd1);
        chk({tag, "_do"}, {16'd0, do_w}, {16'd0, exp});
    endtask

    task automatic wait_eoc(output int e);
        e = -1;
        for (int i = 0; i < 3 * CC; i++) begin
            step();
            if (eoc_w) begin
                e = edges;
                break;
            end
        end
    endtask

    initial begin
        do_reset();
        repeat (20) step();
        // Write aborted by reset two edges after den
        daddr = 7'h40; dwe = 1'b1; di = 16'h5555; den = 1'b1;
        step();
        den = 1'b0; dwe = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("abort_drdy", {31'd0, drdy_w}, 32'd0);
        step();
        step();
        rst = 1'b0;
        edges = 0;
        chk("rst_do", {16'd0, do_w}, 32'h0000);
        chk("rst_drdy", {31'd0, drdy_w}, 32'd0);
        chk("rst_eoc", {31'd0, eoc_w}, 32'd0);
        chk("rst_err", {31'd0, err_w}, 32'd0);
        txn(7'h24, 1'b0, 16'h0, 16'hFFFF, "rst_min");
        txn(7'h20, 1'b0, 16'h0, 16'h0000, "rst_max");
        txn(7'h40, 1'b0, 16'h0, 16'h0000, "abort_cfg");
        txn(7'h00, 1'b0, 16'h0, 16'h0000, "rst_temp");

        // eoc looped back to den as a read of 0x00
        for (int k = 1; k <= 3; k++) begin
            wait_eoc(e_seen);
            chk("eoc_edge", e_seen, k * CC);
            txn(7'h00, 1'b0, 16'h0, 16'h9C40, "conv_read");
            chk("conv_err", {31'd0, err_w}, 32'd0);
        end

        do_reset();
        sample = 12'h800;
        wait_eoc(e_seen);
        chk("mm_eoc1", e_seen, CC);
        sample = 12'hA00;
        wait_eoc(e_seen);
        chk("mm_eoc2", e_seen, 2 * CC);
        sample = 12'h700;
        wait_eoc(e_seen);
        chk("mm_eoc3", e_seen, 3 * CC);
        txn(7'h20, 1'b0, 16'h0, 16'hA000, "mm_max");
        txn(7'h24, 1'b0, 16'h0, 16'h7000, "mm_min");
        txn(7'h00, 1'b0, 16'h0, 16'h7000, "mm_temp");

        txn(7'h41, 1'b1, 16'h1234, 16'h0000, "cfg_wr");
        txn(7'h41, 1'b0, 16'h0, 16'h1234, "cfg_rd");
        txn(7'h05, 1'b0, 16'h0, 16'h0000, "unmapped_rd");
        txn(7'h42, 1'b0, 16'h0, 16'h0000, "cfg_neighbor");
        txn(7'h00, 1'b1, 16'hFFFF, 16'h0000, "ro_wr");
        txn(7'h00, 1'b0, 16'h0, 16'h7000, "ro_unchanged");
        chk("cfg_err", {31'd0, err_w}, 32'd0);

        // Read of 0x00 completing on the edge-400 conversion update
        sample = 12'h123;
        for (int i = 0; i < 500 && edges < 4 * CC - RL - 1; i++) step();
        chk("coll_align", edges, 4 * CC - RL - 1);
        txn(7'h00, 1'b0, 16'h0, 16'h7000, "coll_old");
        chk("coll_eoc", {31'd0, eoc_w}, 32'd1);
        txn(7'h00, 1'b0, 16'h0, 16'h1230, "coll_new");

        // Second den two edges into a transaction
        daddr = 7'h41; dwe = 1'b0; den = 1'b1;
        step();
        den = 1'b0;
        step();
        chk("viol_err_pre", {31'd0, err_w}, 32'd0);
        den = 1'b1;
        step();
        den = 1'b0;
        chk("viol_err", {31'd0, err_w}, 32'd1);
        step();
        chk("viol_no_drdy", {31'd0, drdy_w}, 32'd0);
        step();
        chk("viol_drdy", {31'd0, drdy_w}, 32'd1);
        chk("viol_do", {16'd0, do_w}, 32'h1234);
        drdy_hits = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (drdy_w) drdy_hits++;
        end
        chk("viol_single_drdy", drdy_hits, 0);
        txn(7'h41, 1'b0, 16'h0, 16'h1234, "viol_after");
        chk("viol_sticky", {31'd0, err_w}, 32'd1);
        do_reset();
        chk("viol_cleared", {31'd0, err_w}, 32'd0);
        txn(7'h41, 1'b0, 16'h0, 16'h0000, "cfg_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xadc_drp_responder.md
# xadc_drp_responder

Synthesizable DRP responder that plays the XADC's side of the dynamic reconfiguration port: a periodic conversion engine, a small status/config register file, and the den/drdy read/write handshake. It lets temperature-display logic (DRP initiator, eoc-driven reads of address 0x00) run in simulation and on targets without a hard XADC. Raw 12-bit temperature codes enter on `sample_in`; the initiator sees a 16-bit left-justified result, exactly as from the hard macro.

## Interface
- `CONV_CYCLES`, default 100: clock cycles per conversion (eoc period); legal range is ≥ 2.
- `RD_LATENCY`, default 4: clock edges from den sample to drdy assertion; legal range is ≥ 1.
- `clk` in 1: single clock; all logic runs on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `daddr_in` in 7: DRP address.
- `den_in` in 1: DRP enable; one-cycle strobe.
- `dwe_in` in 1: write enable, qualified by den_in.
- `di_in` in 16: write data.
- `do_out` out 16: read data, valid while drdy_out is high.
- `drdy_out` out 1: one-cycle transaction-complete strobe.
- `eoc_out` out 1: one-cycle end-of-conversion strobe.
- `sample_in` in 12: raw temperature code, sampled at conversion end.
- `err_out` out 1: sticky protocol-violation flag.

## Operation
- Register map:
  - 0x00 temperature, read-only: {sample_in, 4'h0}.
  - 0x20 max temperature, read-only.
  - 0x24 min temperature, read-only.
  - 0x40, 0x41, 0x42 config registers, read/write.
  - All other addresses read 0x0000; writes to them are ignored.
  - Writes to read-only addresses are ignored. A write completes normally with drdy.
- Conversion engine:
  - Free-running counter, 0..CONV_CYCLES-1.
  - On the edge where the counter equals CONV_CYCLES-1:
    - counter returns to 0;
    - 0x00 loads {sample_in, 4'h0};
    - 0x20 loads the new value if it is greater (unsigned, 16-bit);
    - 0x24 loads the new value if it is smaller;
    - eoc_out is high for the following cycle.
- DRP FSM, states IDLE and WAIT:
  - IDLE: when den_in is sampled high, capture daddr_in, dwe_in and di_in, load the latency counter, and go to WAIT.
    - If RD_LATENCY = 1, go straight to the completion edge instead.
  - WAIT: count down. On the completion edge:
    - drdy_out goes high for one cycle;
    - reads: do_out loads the addressed register;
    - writes: the register is updated and do_out loads 0x0000;
    - the FSM returns to IDLE.
  - den_in sampled high while in WAIT: request ignored and err_out set. err_out is cleared only by rst.
  - dwe_in without den_in: no effect.
- do_out holds its last value until the next completion edge.

## Timing
- Reset values:
  - do_out 0x0000, drdy_out 0, eoc_out 0, err_out 0;
  - 0x00 = 0x0000, 0x20 = 0x0000, 0x24 = 0xFFFF;
  - config registers 0x0000;
  - conversion counter 0, FSM IDLE.
- rst asserted mid-transaction aborts it: no drdy, and no write is applied.
- First eoc_out pulse follows edge CONV_CYCLES after reset release (the first edge after release is edge 1). Period is exactly CONV_CYCLES.
- den_in sampled high at edge n gives drdy_out high from edge n+RD_LATENCY to edge n+RD_LATENCY+1.
  - Earliest next accepted den is at edge n+RD_LATENCY+1, i.e. back-to-back while drdy is high.
  - den_in at edges n+1 .. n+RD_LATENCY sets err_out.
- Conversion update and read completion on the same edge: do_out returns the pre-update register value. The new value is readable from the next transaction on.
- Initiator wiring eoc_out → den_in with daddr 0x00 reads each new conversion without error, provided RD_LATENCY < CONV_CYCLES.

## Test plan
- **Reset:** assert rst mid-run, then release. All outputs read 0. A read of 0x24 returns 0xFFFF and a read of 0x20 returns 0x0000, each RD_LATENCY edges after den.
- **Conversion read:** CONV_CYCLES=100, RD_LATENCY=4, sample_in=0x9C4, eoc_out looped to den_in with daddr 0x00. eoc pulses every 100 cycles; drdy follows 4 edges after each den with do_out=0x9C40; err_out stays 0.
- **Min/max tracking:** sample_in = 0x800, 0xA00, 0x700 on three successive conversions. Reads then return 0x20=0xA000, 0x24=0x7000, 0x00=0x7000.
- **Config write/readback:** write 0x1234 to 0x41, then read 0x41 and read 0x05. The write's drdy carries do_out=0x0000; the reads return 0x1234 and 0x0000 respectively. A write of 0xFFFF to 0x00 leaves 0x00 unchanged.
- **Protocol violation:** den at edge n, then den again at edge n+2. Only one drdy occurs, at edge n+4; err_out rises and stays high until rst.
- **Collision and abort:**
  - A read of 0x00 completing on the conversion-update edge returns the old value.
  - rst at edge n+2 of a write: no drdy pulse, and the target register stays 0x0000.
